// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter for a single-port memory with read timeout
module mem_arbiter #(
  parameter int TMO_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        rw0,
  input  logic        rw1,
  input  logic [3:0]  addr0,
  input  logic [3:0]  addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic        rd_err,
  output logic        busy,
  output logic        mem_en,
  output logic        mem_rw,
  output logic [3:0]  mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  input  logic        mem_valid
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] RD_WAIT = 2'd2;
  localparam logic [3:0] TMO     = 4'(TMO_CYCLES);
  logic [1:0] state;
  logic [3:0] cnt;
  logic       ptr;
  logic       owner;
  logic       pend;
  logic       win;
  logic [3:0] cnt_nxt;
  // Winner: pointer holder on contention, otherwise whoever is asking
  always_comb begin
    win     = (req0 & req1) ? ptr : req1;
    cnt_nxt = cnt + 4'd1;
  end
  // Command issue, read return and timeout; mem_rw doubles as the latched access type
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= 1'b0;
      owner    <= 1'b0;
      pend     <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rd_err   <= 1'b0;
      busy     <= 1'b0;
      mem_en   <= 1'b0;
      mem_rw   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      mem_en  <= 1'b0;
      rd_err  <= 1'b0;
      rvalid0 <= pend & ~owner;
      rvalid1 <= pend & owner;
      pend    <= 1'b0;
      case (state)
        IDLE: if (req0 | req1) begin
          owner    <= win;
          ptr      <= ~win;
          gnt0     <= ~win;
          gnt1     <= win;
          mem_en   <= 1'b1;
          mem_rw   <= win ? rw1 : rw0;
          mem_addr <= win ? addr1 : addr0;
          mem_din  <= win ? wdata1 : wdata0;
          busy     <= 1'b1;
          state    <= ISSUE;
        end
        ISSUE: begin
          cnt   <= '0;
          busy  <= mem_rw;
          state <= mem_rw ? RD_WAIT : IDLE;
        end
        RD_WAIT: if (mem_valid) begin
          rdata0 <= owner ? rdata0 : mem_dout;
          rdata1 <= owner ? mem_dout : rdata1;
          pend   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end else begin
          cnt <= cnt_nxt;
          if (cnt_nxt == TMO) begin
            rd_err <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of grant order, read return, timeout and reset abort
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, rw0 = 1'b0, rw1 = 1'b0;
  logic [3:0]  addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, rd_err, busy, mem_en, mem_rw;
  logic [31:0] rdata0, rdata1, mem_din;
  logic [3:0]  mem_addr;
  logic [31:0] mem_dout = '0;
  logic        mem_valid = 1'b0;
  logic        mem_ok = 1'b1;
  logic [31:0] mem [16];
  int          n_cmp = 0;
  int          n_bad = 0;

  mem_arbiter #(.TMO_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rd_err(rd_err), .busy(busy),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_valid(mem_valid)
  );

  always #5 clk = ~clk;

  // One-cycle memory: samples on the edge that ends ISSUE, returns data the following cycle
  always @(posedge clk) begin
    if (mem_en && !mem_rw) mem[mem_addr] <= mem_din;
    mem_valid <= mem_en & mem_rw & mem_ok;
    if (mem_en && mem_rw) mem_dout <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    rst_n = 1'b1;
    tick();
    // single write from requester 0
    req0 = 1'b1; rw0 = 1'b0; addr0 = 4'd3; wdata0 = 32'hDEADBEEF;
    tick();
    check("wr_gnt0", 32'(gnt0), 32'd1);
    check("wr_gnt1", 32'(gnt1), 32'd0);
    check("wr_mem_en", 32'(mem_en), 32'd1);
    check("wr_mem_rw", 32'(mem_rw), 32'd0);
    check("wr_mem_addr", 32'(mem_addr), 32'd3);
    check("wr_mem_din", mem_din, 32'hDEADBEEF);
    check("wr_busy", 32'(busy), 32'd1);
    req0 = 1'b0;
    tick();
    check("wr_done_en", 32'(mem_en), 32'd0);
    check("wr_done_busy", 32'(busy), 32'd0);
    check("wr_hold_addr", 32'(mem_addr), 32'd3);
    // read back through requester 1
    req1 = 1'b1; rw1 = 1'b1; addr1 = 4'd3;
    tick();
    check("rd_gnt1", 32'(gnt1), 32'd1);
    check("rd_mem_rw", 32'(mem_rw), 32'd1);
    req1 = 1'b0;
    tick();
    check("rd_c2_rvalid", 32'(rvalid1), 32'd0);
    tick();
    check("rd_c3_rvalid", 32'(rvalid1), 32'd0);
    tick();
    check("rd_c4_rvalid1", 32'(rvalid1), 32'd1);
    check("rd_c4_rvalid0", 32'(rvalid0), 32'd0);
    check("rd_c4_rdata1", rdata1, 32'hDEADBEEF);
    check("rd_c4_rdata0", rdata0, 32'd0);
    tick();
    check("rd_c5_rvalid", 32'(rvalid1), 32'd0);
    // contention: both write continuously, pointer now favours requester 0
    req0 = 1'b1; rw0 = 1'b0; addr0 = 4'd5; wdata0 = 32'h12345678;
    req1 = 1'b1; rw1 = 1'b0; addr1 = 4'd6; wdata1 = 32'hA5A5A5A5;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("rr_gnt0_%0d", k), 32'(gnt0), 32'((k % 4) == 0));
      check($sformatf("rr_gnt1_%0d", k), 32'(gnt1), 32'((k % 4) == 2));
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    // read addr 5 into requester 0; requester 1's data must hold
    req0 = 1'b1; rw0 = 1'b1; addr0 = 4'd5;
    tick();
    check("rd0_gnt0", 32'(gnt0), 32'd1);
    req0 = 1'b0;
    repeat (3) tick();
    check("rd0_rvalid0", 32'(rvalid0), 32'd1);
    check("rd0_rdata0", rdata0, 32'h12345678);
    check("rd0_rdata1_hold", rdata1, 32'hDEADBEEF);
    tick();
    // timeout: memory never answers
    mem_ok = 1'b0;
    req1 = 1'b1; rw1 = 1'b1; addr1 = 4'd6;
    tick();
    check("to_gnt1", 32'(gnt1), 32'd1);
    req1 = 1'b0;
    for (int k = 2; k <= 8; k++) begin
      tick();
      check($sformatf("to_err_%0d", k), 32'(rd_err), 32'(k == 6));
      check($sformatf("to_rvalid_%0d", k), 32'(rvalid1), 32'd0);
      check($sformatf("to_busy_%0d", k), 32'(busy), 32'(k <= 5));
    end
    check("to_rdata1_hold", rdata1, 32'hDEADBEEF);
    // reset in the middle of a stalled read
    req1 = 1'b1; rw1 = 1'b1; addr1 = 4'd5;
    tick();
    check("rr_gnt1_pre", 32'(gnt1), 32'd1);
    req1 = 1'b0;
    repeat (2) tick();
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_rdata0", rdata0, 32'd0);
    check("arst_rdata1", rdata1, 32'd0);
    check("arst_mem", {27'd0, mem_addr, mem_rw}, 32'd0);
    mem_ok = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("post_rst_quiet_%0d", k), {28'd0, rvalid1, rvalid0, rd_err, gnt1}, 32'd0);
    end
    req0 = 1'b1; rw0 = 1'b0; addr0 = 4'd7; wdata0 = 32'h0BADF00D;
    req1 = 1'b1; rw1 = 1'b0; addr1 = 4'd8; wdata1 = 32'h00C0FFEE;
    tick();
    check("post_rst_gnt0", 32'(gnt0), 32'd1);
    check("post_rst_gnt1", 32'(gnt1), 32'd0);
    check("post_rst_din", mem_din, 32'h0BADF00D);
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TMO_CYCLES, default 4: maximum RD_WAIT cycles allowed before a read is aborted; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req0, req1  input  1 each  access request from requester 0 or 1; held high until the matching gnt.
REQ-005 rw0, rw1  input  1 each  access type: 1 = read, 0 = write.
REQ-006 addr0, addr1  input  4 each  target word address.
REQ-007 wdata0, wdata1  input  32 each  write data.
REQ-008 gnt0, gnt1  output  1 each  one-cycle pulse; the command was issued to memory.
REQ-009 rdata0, rdata1  output  32 each  read data; valid while the matching rvalid is high.
REQ-010 rvalid0, rvalid1  output  1 each  one-cycle read-return pulse.
REQ-011 rd_err  output  1  one-cycle pulse; a read timed out.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 mem_en, mem_rw  output  1 each  memory enable and read/write select (1 = read).
REQ-014 mem_addr  output  4  memory address.
REQ-015 mem_din  output  32  memory write data.
REQ-016 mem_dout  input  32  memory read data.
REQ-017 mem_valid  input  1  memory read-valid; arrives one cycle after the memory samples a read.

Function
REQ-018 FSM states: IDLE, ISSUE, RD_WAIT; all outputs registered.
REQ-019 IDLE with any req high: select winner by round-robin; latch its rw, addr and wdata; next state ISSUE.
REQ-020 Round-robin: a one-bit pointer names the priority requester; if both req are high, the pointer holder wins; if only one is high, that requester wins.
REQ-021 After each grant, the pointer moves to the requester that was not granted.
REQ-022 ISSUE, exactly one cycle: mem_en=1; mem_rw/mem_addr/mem_din driven from the latched command; the winner's gnt=1.
REQ-023 ISSUE transitions: latched write -> IDLE; latched read -> RD_WAIT with timeout counter cleared.
REQ-024 Outside ISSUE: mem_en=0; mem_rw/mem_addr/mem_din hold their last values.
REQ-025 RD_WAIT with mem_valid=1: capture mem_dout into the owner's rdata; pulse the owner's rvalid the next cycle; go to IDLE.
REQ-026 RD_WAIT with mem_valid=0: increment the 4-bit timeout counter.
REQ-027 Timeout: when the counter reaches TMO_CYCLES with no mem_valid, pulse rd_err and go to IDLE; the owner's rdata is unchanged and its rvalid stays 0.
REQ-028 mem_valid outside RD_WAIT is ignored.
REQ-029 Request sampling: req is sampled only in IDLE; a req raised during ISSUE or RD_WAIT waits.
REQ-030 Throughput: write-to-write minimum spacing is 2 cycles; read latency from req sampled to rvalid is 4 cycles with a one-cycle memory.
REQ-031 The non-owner's rdata holds its value across other transactions.

Reset
REQ-032 rst_n low asynchronously forces: state IDLE; pointer=0; counter=0.
REQ-033 rst_n low asynchronously forces these outputs to 0: gnt*, rvalid*, rd_err, busy, mem_en, mem_rw, mem_addr, mem_din, rdata0, rdata1.
REQ-034 Reset mid-transaction abandons the transaction: no gnt, rvalid or rd_err for it after release.
REQ-035 First edge after rst_n rises behaves as IDLE.

Verification
REQ-036 Write: req0=1, rw0=0, addr0=3, wdata0=0xDEADBEEF -> next cycle mem_en=1, mem_rw=0, mem_addr=3, mem_din=0xDEADBEEF, gnt0=1; then IDLE.
REQ-037 Read with a one-cycle memory: req1 read of addr 3 -> gnt1 in ISSUE, then rvalid1=1 with rdata1=0xDEADBEEF exactly 4 cycles after req was sampled; rdata0 unchanged.
REQ-038 Contention: req0 and req1 held high continuously after reset -> grants alternate gnt0, gnt1, gnt0, gnt1; never two consecutive grants to one requester.
REQ-039 Timeout: read issued with mem_valid tied 0, TMO_CYCLES=4 -> rd_err pulses once after 4 RD_WAIT cycles; rvalid stays 0; FSM returns to IDLE.
REQ-040 Reset mid-read: rst_n low during RD_WAIT -> all outputs immediately 0; after release no rvalid for the aborted read, and the next request is served with pointer=0.
